// File: rtl/wb_burst_ram.sv
// Wishbone B3 slave RAM: classic and registered-feedback incrementing bursts
// with linear/wrap-4/8/16 address generation and a programmable first-beat latency.
module wb_burst_ram #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        wbm_clk_i,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [31:2] wbs_addr_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_data_i,
  output logic [31:0] wbs_data_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_BURST, S_ERR} state_t;

  localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH;
  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [2:0]  CTI_INCR    = 3'b010;
  localparam logic [2:0]  CTI_EOB     = 3'b111;

  logic [31:0] mem [DEPTH];

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] beat_addr, beat_addr_n;
  logic [ADDR_WIDTH-1:0] next_addr, rd_addr, req_addr, wrap_mask;
  logic                  burst, burst_n;
  logic                  ack_n, err_n, load;
  logic                  req, wr_en, cti_reserved;
  logic [31:0]           rd_word;
  logic                  unused_addr;

  assign req          = wbs_cyc_i & wbs_stb_i;
  assign req_addr     = wbs_addr_i[ADDR_WIDTH+1:2];
  assign wr_en        = wbs_ack_o & req & wbs_we_i & ~rst;
  assign cti_reserved = !((wbs_cti_i == CTI_CLASSIC) || (wbs_cti_i == CTI_INCR) ||
                          (wbs_cti_i == CTI_EOB));
  assign unused_addr  = ^wbs_addr_i[31:ADDR_WIDTH+2];

  // Linear bursts use an all-ones mask, so one expression covers every bte.
  always_comb begin
    case (wbs_bte_i)
      2'b01:   wrap_mask = ADDR_WIDTH'(3);
      2'b10:   wrap_mask = ADDR_WIDTH'(7);
      2'b11:   wrap_mask = ADDR_WIDTH'(15);
      default: wrap_mask = '1;
    endcase
    next_addr = (beat_addr & ~wrap_mask) | ((beat_addr + 1'b1) & wrap_mask);
  end

  // Forward same-edge write lanes so a read of the beat being written sees new data.
  always_comb begin
    rd_word = mem[rd_addr];
    if (wr_en && (rd_addr == beat_addr)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wbs_sel_i[i]) rd_word[8*i +: 8] = wbs_data_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    beat_addr_n = beat_addr;
    burst_n     = burst;
    ack_n       = wbs_ack_o;
    err_n       = 1'b0;
    load        = 1'b0;
    rd_addr     = beat_addr;
    case (state)
      S_IDLE: begin
        ack_n = 1'b0;
        if (req) begin
          if (cti_reserved) begin
            err_n   = 1'b1;
            state_n = S_ERR;
          end else begin
            beat_addr_n = req_addr;
            burst_n     = (wbs_cti_i == CTI_INCR);
            rd_addr     = req_addr;
            if (WAIT_STATES == 0) begin
              ack_n   = 1'b1;
              load    = 1'b1;
              state_n = burst_n ? S_BURST : S_ACK;
            end else begin
              cnt_n   = 4'(WAIT_STATES - 1);
              state_n = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i) begin
          state_n = S_IDLE;
        end else if (cnt == '0) begin
          ack_n   = 1'b1;
          load    = 1'b1;
          state_n = burst ? S_BURST : S_ACK;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_ACK: begin
        ack_n   = 1'b0;
        state_n = S_IDLE;
      end
      S_BURST: begin
        if (!wbs_cyc_i) begin
          ack_n   = 1'b0;
          state_n = S_IDLE;
        end else if (!wbs_stb_i) begin
          ack_n = 1'b0;
        end else if (!wbs_ack_o) begin
          // Resuming after a pause: re-present the held beat.
          ack_n = 1'b1;
          load  = 1'b1;
        end else if (wbs_cti_i == CTI_EOB) begin
          ack_n   = 1'b0;
          state_n = S_IDLE;
        end else begin
          beat_addr_n = next_addr;
          rd_addr     = next_addr;
          ack_n       = 1'b1;
          load        = 1'b1;
        end
      end
      S_ERR: begin
        state_n = S_IDLE;
      end
      default: begin
        ack_n   = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wbm_clk_i) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      beat_addr  <= '0;
      burst      <= 1'b0;
      wbs_ack_o  <= 1'b0;
      wbs_err_o  <= 1'b0;
      wbs_data_o <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      beat_addr <= beat_addr_n;
      burst     <= burst_n;
      wbs_ack_o <= ack_n;
      wbs_err_o <= err_n;
      if (load) wbs_data_o <= rd_word;
    end
  end

  always_ff @(posedge wbm_clk_i) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wbs_sel_i[i]) mem[beat_addr][8*i +: 8] <= wbs_data_i[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
// Bench for wb_burst_ram: directed bus transactions push expected responses to a
// scoreboard queue; a negedge monitor pops and compares on every completed beat or error.
module tb_wb_burst_ram;

  localparam int WS = 1;
  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_ERR = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:2] addr;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [3:0]  sel;
  logic [31:0] wdat, rdat;
  logic        ack, err;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  logic [31:0] bw [16];
  logic [31:0] bx [16];

  always #5 clk = ~clk;

  wb_burst_ram #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
    .wbm_clk_i (clk),
    .rst       (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_addr_i(addr),
    .wbs_cti_i (cti),
    .wbs_bte_i (bte),
    .wbs_sel_i (sel),
    .wbs_we_i  (we),
    .wbs_data_i(wdat),
    .wbs_data_o(rdat),
    .wbs_ack_o (ack),
    .wbs_err_o (err)
  );

  // Monitor: a beat completes at the coming edge when ack, cyc and stb are all high.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] got;
    if (!rst && ((ack && cyc && stb) || err)) begin
      total++;
      got = err ? K_ERR : (we ? K_WR : K_RD);
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: kind=%0d data=%h, no response expected", got, rdat);
      end else begin
        e = sb.pop_front();
        if (got != e.kind || (e.kind == K_RD && rdat !== e.data)) begin
          bad++;
          $display("FAIL sb_rsp: kind=%0d data=%h, required kind=%0d data=%h",
                   got, rdat, e.kind, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!ack && c < 32);
    if (!ack) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: ack=%0b after %0d cycles, required 1", ack, c);
    end
  endtask

  task automatic classic(input int unsigned word, input bit wr, input logic [3:0] s,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
    int c;
    sb.push_back('{wr ? K_WR : K_RD, exp_rd});
    @(negedge clk);
    addr = 30'(word); we = wr; sel = s; wdat = wd; cti = 3'b000; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1;
    wait_ack(c);
    check("classic_latency", c, WS + 1);
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("classic_ack_one_cycle", ack, 0);
  endtask

  task automatic burst(input int unsigned word, input logic [1:0] bt, input bit wr, input int n,
                       input int pause_after, input int stop_after, input bit stop_rst);
    int c;
    @(negedge clk);
    addr = 30'(word); bte = bt; we = wr; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < n; i++) begin
      cti  = (i == n - 1) ? 3'b111 : 3'b010;
      wdat = bw[i];
      sb.push_back('{wr ? K_WR : K_RD, bx[i]});
      wait_ack(c);
      check("beat_latency", c, (i == 0) ? WS + 1 : 1);
      @(posedge clk);
      #1;
      if (i == n - 1) begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        @(negedge clk);
        check("burst_end_ack", ack, 0);
      end else if (i == stop_after) begin
        if (stop_rst) begin
          rst  = 1'b1;
          wdat = bw[i+1];
        end else begin
          cyc = 1'b0; stb = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        check(stop_rst ? "rst_burst_ack" : "abort_ack", ack, 0);
        if (stop_rst) check("rst_burst_data", rdat, 0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        return;
      end else if (i == pause_after) begin
        stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pause_ack_1", ack, 0);
        @(posedge clk);
        #1 stb = 1'b1;
        @(negedge clk);
        check("pause_ack_2", ack, 0);
      end
    end
  endtask

  task automatic err_req();
    sb.push_back('{K_ERR, 32'h0});
    @(negedge clk);
    addr = 30'h40; we = 1'b0; sel = 4'hF; cti = 3'b011; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    check("err_set", err, 1);
    check("err_no_ack", ack, 0);
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    @(negedge clk);
    check("err_one_cycle", err, 0);
    check("err_no_ack_2", ack, 0);
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0;
    cti = 3'b000; bte = 2'b00; sel = 4'h0; wdat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", ack, 0);
    check("reset_err", err, 0);
    check("reset_data", rdat, 0);
    rst = 1'b0;

    // Classic write/read and byte-lane merge
    classic(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0);
    classic(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF);
    classic(32'h10, 1'b1, 4'h4, 32'h00AA0000, 32'h0);
    classic(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAABEEF);

    // Preload words used by the bursts
    for (int unsigned w = 32'h20; w < 32'h24; w++) classic(w, 1'b1, 4'hF, w, 32'h0);
    classic(32'h26, 1'b1, 4'hF, 32'h26, 32'h0);
    classic(32'h27, 1'b1, 4'hF, 32'h27, 32'h0);
    classic(32'h32, 1'b1, 4'hF, 32'h55550032, 32'h0);

    // 4-beat linear read burst from 0x20
    for (int i = 0; i < 4; i++) begin bw[i] = '0; bx[i] = 32'h20 + 32'(i); end
    burst(32'h20, 2'b00, 1'b0, 4, -1, -1, 1'b0);

    // Wrap-8 read burst from 0x26: 0x26, 0x27, 0x20, 0x21
    bx[0] = 32'h26; bx[1] = 32'h27; bx[2] = 32'h20; bx[3] = 32'h21;
    burst(32'h26, 2'b10, 1'b0, 4, -1, -1, 1'b0);

    // Wrap-4 write burst from 0x0E, data 1..4
    for (int i = 0; i < 4; i++) begin bw[i] = 32'(i + 1); bx[i] = '0; end
    burst(32'h0E, 2'b01, 1'b1, 4, -1, -1, 1'b0);
    classic(32'h0C, 1'b0, 4'hF, 32'h0, 32'h3);
    classic(32'h0D, 1'b0, 4'hF, 32'h0, 32'h4);
    classic(32'h0E, 1'b0, 4'hF, 32'h0, 32'h1);
    classic(32'h0F, 1'b0, 4'hF, 32'h0, 32'h2);
    classic(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAABEEF);

    // Pause: stb low for 2 cycles after the second beat
    for (int i = 0; i < 4; i++) begin bw[i] = '0; bx[i] = 32'h20 + 32'(i); end
    burst(32'h20, 2'b00, 1'b0, 4, 1, -1, 1'b0);

    // Abort: cyc dropped after the second beat, then a fresh classic read
    burst(32'h20, 2'b00, 1'b0, 4, -1, 1, 1'b0);
    classic(32'h21, 1'b0, 4'hF, 32'h0, 32'h21);

    // Reserved cti
    err_req();

    // Reset in the middle of a write burst at 0x30
    for (int i = 0; i < 4; i++) begin bw[i] = 32'hA0 + 32'(i); bx[i] = '0; end
    burst(32'h30, 2'b00, 1'b1, 4, -1, 1, 1'b1);
    classic(32'h30, 1'b0, 4'hF, 32'h0, 32'hA0);
    classic(32'h31, 1'b0, 4'hF, 32'h0, 32'hA1);
    classic(32'h32, 1'b0, 4'hF, 32'h0, 32'h55550032);
    classic(32'h10, 1'b0, 4'hF, 32'h0, 32'hDEAABEEF);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
